// File: rtl/mips_cpu_hilo_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers, with MTHI/MTLO and a busy/done handshake.
// Build option MIPS_CPU_FAST_MULT_EN: multiplies complete in one cycle; divides stay iterative.
module mips_cpu_hilo_muldiv (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        mthi,
    input  logic        mtlo,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    logic [1:0]  state_reg;
    logic [5:0]  count_reg;
    logic [63:0] acc_reg;
    logic [31:0] opnd_reg;
    logic        is_div_reg;
    logic        div_zero_reg;
    logic        neg_res_reg;
    logic        neg_rem_reg;
    logic        done_reg;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;

    logic        is_signed_op;
    logic        is_div_op;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic        div_by_zero;
    logic        fast_mult;

    assign is_signed_op = ~op[0];
    assign is_div_op    = op[1];
    assign a_neg        = is_signed_op & rs_data[31];
    assign b_neg        = is_signed_op & rt_data[31];
    assign a_abs        = a_neg ? -rs_data : rs_data;
    assign b_abs        = b_neg ? -rt_data : rt_data;
    assign div_by_zero  = is_div_op & (rt_data == 32'd0);

`ifdef MIPS_CPU_FAST_MULT_EN
    logic [63:0] fast_prod;
    // Truncated product of sign-extended operands equals the signed product modulo 2^64.
    assign fast_prod = {{32{a_neg}}, rs_data} * {{32{b_neg}}, rt_data};
    assign fast_mult = ~is_div_op;
`else
    assign fast_mult = 1'b0;
`endif

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    assign mul_sum  = {1'b0, acc_reg[63:32]} + (acc_reg[0] ? {1'b0, opnd_reg} : 33'd0);
    assign mul_next = {mul_sum, acc_reg[31:1]};

    // Divide: acc = {remainder, dividend/quotient}; bit 63 carries the shifted-out remainder MSB.
    logic        div_fits;
    logic [31:0] div_diff;
    logic [63:0] div_next;
    assign div_fits = acc_reg[63:31] >= {1'b0, opnd_reg};
    assign div_diff = acc_reg[62:31] - opnd_reg;
    assign div_next = div_fits ? {div_diff, acc_reg[30:0], 1'b1} : {acc_reg[62:0], 1'b0};

    logic [63:0] prod_fix;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;
    assign prod_fix = neg_res_reg ? -acc_reg : acc_reg;
    assign quot_fix = neg_res_reg ? -acc_reg[31:0] : acc_reg[31:0];
    assign rem_fix  = neg_rem_reg ? -acc_reg[63:32] : acc_reg[63:32];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            count_reg    <= 6'd0;
            acc_reg      <= 64'd0;
            opnd_reg     <= 32'd0;
            is_div_reg   <= 1'b0;
            div_zero_reg <= 1'b0;
            neg_res_reg  <= 1'b0;
            neg_rem_reg  <= 1'b0;
            done_reg     <= 1'b0;
            hi_reg       <= 32'd0;
            lo_reg       <= 32'd0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        if (fast_mult) begin
`ifdef MIPS_CPU_FAST_MULT_EN
                            hi_reg   <= fast_prod[63:32];
                            lo_reg   <= fast_prod[31:0];
                            done_reg <= 1'b1;
`endif
                        end else begin
                            // Divide by zero preloads the architectural result so FIX needs no special path.
                            opnd_reg     <= is_div_op ? b_abs : a_abs;
                            acc_reg      <= div_by_zero ? {rs_data, 32'hFFFF_FFFF}
                                                        : {32'd0, (is_div_op ? a_abs : b_abs)};
                            is_div_reg   <= is_div_op;
                            div_zero_reg <= div_by_zero;
                            neg_res_reg  <= ~div_by_zero & (a_neg ^ b_neg);
                            neg_rem_reg  <= ~div_by_zero & a_neg;
                            count_reg    <= 6'd0;
                            state_reg    <= RUN;
                        end
                    end else begin
                        if (mthi) hi_reg <= rs_data;
                        if (mtlo) lo_reg <= rs_data;
                    end
                end
                RUN: begin
                    if (div_zero_reg) begin
                        state_reg <= FIX;
                    end else begin
                        acc_reg   <= is_div_reg ? div_next : mul_next;
                        count_reg <= count_reg + 6'd1;
                        if (count_reg == 6'd31) state_reg <= FIX;
                    end
                end
                FIX: begin
                    if (is_div_reg) begin
                        hi_reg <= rem_fix;
                        lo_reg <= quot_fix;
                    end else begin
                        hi_reg <= prod_fix[63:32];
                        lo_reg <= prod_fix[31:0];
                    end
                    done_reg  <= 1'b1;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy = (state_reg != IDLE);
    assign done = done_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;
endmodule
